// File: rtl/milano_alu_seq.sv
// Integer execute unit: registered single-cycle RV32I ALU ops plus an iterative
// shift-add unsigned multiplier (MUL/MULHU), valid/ready issue and flush.
//
// state    | meaning
// IDLE     | ready for issue; single-cycle ops complete from here
// MUL_BUSY | multiplier iterating, issue blocked
module milano_alu_seq #(
  parameter int XLEN       = 32,
  parameter int MUL_STEP   = 1,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [3:0]            operator_i,
  input  logic [XLEN-1:0]       operand_a_i,
  input  logic [XLEN-1:0]       operand_b_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  output logic                  valid_o,
  output logic                  reg_we_o,
  output logic [REG_ADDR_W-1:0] wr_addr_o,
  output logic [XLEN-1:0]       rd_wdata_o
);

  localparam int SHW   = $clog2(XLEN);
  localparam int STEPS = XLEN / MUL_STEP;
  localparam int CW    = $clog2(STEPS + 1);
  localparam bit ONE_SHOT = (STEPS == 1);
  localparam logic [CW-1:0] STEPS_M1 = CW'(STEPS - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] MUL_BUSY = 1'b1;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_SLL   = 4'd2;
  localparam logic [3:0] OP_SLT   = 4'd3;
  localparam logic [3:0] OP_SLTU  = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_OR    = 4'd8;
  localparam logic [3:0] OP_AND   = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_MULHU = 4'd11;

  logic [0:0]            state;
  logic [CW-1:0]         cnt;
  logic [2*XLEN-1:0]     acc;
  logic [2*XLEN-1:0]     mcand;
  logic [XLEN-1:0]       mplier;
  logic                  mul_hi;
  logic [REG_ADDR_W-1:0] mul_rd;

  logic                  accept;
  logic                  is_mul;
  logic                  alu_legal;
  logic [XLEN-1:0]       alu_res;
  logic [SHW-1:0]        shamt;
  logic [2*XLEN-1:0]     step_acc;
  logic [2*XLEN-1:0]     step_mcand;
  logic [XLEN-1:0]       step_mplier;
  logic [2*XLEN-1:0]     partial;
  logic [2*XLEN-1:0]     step_sum;

  assign ready_o = (state == IDLE);
  assign accept  = valid_i & ready_o & ~flush_i;
  assign is_mul  = (operator_i == OP_MUL) || (operator_i == OP_MULHU);
  assign shamt   = operand_b_i[SHW-1:0];

  always_comb begin
    alu_legal = 1'b1;
    alu_res   = '0;
    case (operator_i)
      OP_ADD:   alu_res = operand_a_i + operand_b_i;
      OP_SUB:   alu_res = operand_a_i - operand_b_i;
      OP_SLL:   alu_res = operand_a_i << shamt;
      OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(operand_a_i) < $signed(operand_b_i)};
      OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, operand_a_i < operand_b_i};
      OP_XOR:   alu_res = operand_a_i ^ operand_b_i;
      OP_SRL:   alu_res = operand_a_i >> shamt;
      OP_SRA:   alu_res = $signed(operand_a_i) >>> shamt;
      OP_OR:    alu_res = operand_a_i | operand_b_i;
      OP_AND:   alu_res = operand_a_i & operand_b_i;
      OP_MUL,
      OP_MULHU: alu_res = '0;
      default:  alu_legal = 1'b0;
    endcase
  end

  // The accept edge already retires the first chunk, so the strobe lands
  // exactly STEPS cycles after issue.
  assign step_acc    = (state == IDLE) ? '0 : acc;
  assign step_mcand  = (state == IDLE) ? {{XLEN{1'b0}}, operand_a_i} : mcand;
  assign step_mplier = (state == IDLE) ? operand_b_i : mplier;

  always_comb begin
    partial = '0;
    for (int i = 0; i < MUL_STEP; i++) begin
      if (step_mplier[i]) partial = partial + (step_mcand << i);
    end
    step_sum = step_acc + partial;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      cnt        <= '0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      mul_hi     <= 1'b0;
      mul_rd     <= '0;
      valid_o    <= 1'b0;
      reg_we_o   <= 1'b0;
      wr_addr_o  <= '0;
      rd_wdata_o <= '0;
    end else begin
      valid_o  <= 1'b0;
      reg_we_o <= 1'b0;
      if (state == IDLE) begin
        if (accept) begin
          if (is_mul && !ONE_SHOT) begin
            state  <= MUL_BUSY;
            acc    <= step_sum;
            mcand  <= step_mcand << MUL_STEP;
            mplier <= step_mplier >> MUL_STEP;
            cnt    <= STEPS_M1;
            mul_hi <= (operator_i == OP_MULHU);
            mul_rd <= rd_addr_i;
          end else begin
            valid_o   <= 1'b1;
            wr_addr_o <= rd_addr_i;
            reg_we_o  <= alu_legal && (rd_addr_i != '0);
            if (!is_mul)
              rd_wdata_o <= alu_res;
            else if (operator_i == OP_MULHU)
              rd_wdata_o <= step_sum[2*XLEN-1:XLEN];
            else
              rd_wdata_o <= step_sum[XLEN-1:0];
          end
        end
      end else begin
        if (flush_i) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          acc    <= step_sum;
          mcand  <= step_mcand << MUL_STEP;
          mplier <= step_mplier >> MUL_STEP;
          cnt    <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state      <= IDLE;
            valid_o    <= 1'b1;
            wr_addr_o  <= mul_rd;
            reg_we_o   <= (mul_rd != '0);
            rd_wdata_o <= mul_hi ? step_sum[2*XLEN-1:XLEN] : step_sum[XLEN-1:0];
          end
        end
      end
    end
  end

endmodule
